// File: rtl/ram_uart_streamer.sv
// rtl/ram_uart_streamer.sv - walks a RAM address window and streams each word to the UART
// Read-clock-domain dump engine: FETCH/CAPTURE hide the 1-cycle RAM latency, SEND holds the byte.
module ram_uart_streamer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] read_addr,
  input  logic [DATA_WIDTH-1:0] q,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    CAPTURE = 2'd2,
    SEND    = 2'd3
  } state_t;

  state_t              state;
  logic [ADDR_WIDTH:0] remaining;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      read_addr <= '0;
      remaining <= '0;
      tx_data   <= '0;
      tx_valid  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        // abort wins over any handshake in flight; the offered word is discarded
        tx_valid <= 1'b0;
        done     <= 1'b1;
        busy     <= 1'b0;
        state    <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              if (word_count != '0) begin
                read_addr <= start_addr;
                remaining <= word_count;
                busy      <= 1'b1;
                state     <= FETCH;
              end else begin
                done <= 1'b1;
              end
            end
          end
          FETCH: begin
            state <= CAPTURE;
          end
          CAPTURE: begin
            tx_data   <= q;
            tx_valid  <= 1'b1;
            remaining <= remaining - (ADDR_WIDTH+1)'(1);
            state     <= SEND;
          end
          SEND: begin
            if (tx_ready) begin
              tx_valid <= 1'b0;
              if (remaining != '0) begin
                read_addr <= read_addr + ADDR_WIDTH'(1);
                state     <= FETCH;
              end else begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end
            end
          end
          default: begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_uart_streamer.sv
// tb/tb_ram_uart_streamer.sv - randomized dumps checked against a queue-based RAM window model
module tb_ram_uart_streamer;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic          clock = 1'b0;
  logic          reset, start, abort, tx_ready;
  logic [AW-1:0] start_addr, read_addr;
  logic [AW:0]   word_count;
  logic [DW-1:0] q, tx_data;
  logic          tx_valid, busy, done;
  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail = 0;
  int done_count = 0;
  logic [DW-1:0] got_data[$];
  int            got_addr[$];
  logic          prev_valid = 1'b0, prev_xfer = 1'b0, prev_done = 1'b0;
  logic [DW-1:0] prev_data = '0;

  ram_uart_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
    .word_count(word_count), .abort(abort), .read_addr(read_addr), .q(q),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  // registered RAM read port
  always @(posedge clock) q <= mem[read_addr];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (done) begin
      check_eq("done_vs_valid", tx_valid, 0);
      check_eq("busy_at_done", busy, 0);
      check_eq("done_width", prev_done, 0);
      done_count++;
    end
    if (tx_valid && prev_valid && !prev_xfer) check_eq("hold_data", tx_data, prev_data);
    if (tx_valid && tx_ready && !abort && !reset) begin
      got_data.push_back(tx_data);
      got_addr.push_back(int'(read_addr));
    end
    prev_valid = tx_valid;
    prev_data  = tx_data;
    prev_xfer  = tx_valid && (tx_ready || abort);
    prev_done  = done;
  end

  // mode 0: ready held high, 1: random ready, 2: ready low for 10 cycles of every offered word
  task automatic run_dump(input int sa, input int cnt, input int mode, input bit poke);
    logic [DW-1:0] exp_d[$];
    int exp_a[$];
    int d0, cyc, w_stall, tot_stall, a;
    bit seen, busy_seen;
    for (int i = 0; i < cnt; i++) begin
      a = (sa + i) % DEPTH;
      exp_a.push_back(a);
      exp_d.push_back(mem[a]);
    end
    got_data.delete();
    got_addr.delete();
    d0 = done_count;
    cyc = 0; w_stall = 0; tot_stall = 0; seen = 0; busy_seen = 0;
    @(posedge clock); #1;
    start = 1'b1; start_addr = AW'(sa); word_count = (AW+1)'(cnt);
    tx_ready = (mode == 0);
    @(posedge clock); #1;
    start = 1'b0;
    while (done_count == d0 && cyc < 2000) begin
      @(negedge clock); #1;
      cyc++;
      if (busy) busy_seen = 1;
      if (tx_valid && !seen) begin
        seen = 1;
        check_eq("first_valid_latency", cyc, 3);
      end
      if (tx_valid && !tx_ready) begin w_stall++; tot_stall++; end
      if (tx_valid && tx_ready) w_stall = 0;
      @(posedge clock); #1;
      if (poke && cyc == 5) begin
        start = 1'b1; start_addr = 4'd3; word_count = 5'd2;
      end else begin
        start = 1'b0;
      end
      case (mode)
        0: tx_ready = 1'b1;
        1: tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = tx_valid ? (w_stall >= 10) : 1'($urandom_range(0, 1));
      endcase
    end
    check_eq("dump_timeout", cyc < 2000, 1);
    if (cnt == 0) begin
      check_eq("zero_done_cycle", cyc, 1);
      check_eq("zero_busy_seen", busy_seen, 0);
    end
    if (mode == 2) check_eq("stall_cycles", tot_stall, 10 * cnt);
    check_eq("word_count_out", got_data.size(), cnt);
    for (int i = 0; i < cnt && i < got_data.size(); i++) begin
      check_eq("byte", got_data[i], exp_d[i]);
      check_eq("addr", got_addr[i], exp_a[i]);
    end
    @(negedge clock); #1;
    check_eq("done_pulses", done_count - d0, 1);
    check_eq("idle_after", busy, 0);
  endtask

  initial begin
    int d0, cyc;
    reset = 1'b1; start = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    start_addr = '0; word_count = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'hA0 + 8'(i);
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_eq("rst_read_addr", read_addr, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    @(posedge clock); #1;
    reset = 1'b0;

    run_dump(0, 4, 0, 0);
    run_dump(14, 4, 0, 0);
    run_dump(7, 2, 2, 0);
    run_dump(9, 0, 0, 0);
    run_dump(5, 16, 1, 1);

    // abort in SEND while tx_ready is high: word discarded
    got_data.delete();
    @(posedge clock); #1;
    start = 1'b1; start_addr = 4'd2; word_count = 5'd3; tx_ready = 1'b0;
    @(posedge clock); #1;
    start = 1'b0;
    cyc = 0;
    while (!tx_valid && cyc < 20) begin @(negedge clock); #1; cyc++; end
    check_eq("abort_reach_send", tx_valid, 1);
    @(posedge clock); #1;
    abort = 1'b1; tx_ready = 1'b1;
    d0 = done_count;
    @(posedge clock); #1;
    abort = 1'b0; tx_ready = 1'b0;
    @(negedge clock); #1;
    check_eq("abort_valid", tx_valid, 0);
    check_eq("abort_done", done, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_no_xfer", got_data.size(), 0);
    check_eq("abort_done_pulses", done_count - d0, 1);

    // abort together with start in IDLE: start dropped
    @(posedge clock); #1;
    start = 1'b1; abort = 1'b1; start_addr = 4'd0; word_count = 5'd4;
    @(posedge clock); #1;
    start = 1'b0; abort = 1'b0;
    @(negedge clock); #1;
    check_eq("abort_start_busy", busy, 0);
    check_eq("abort_start_done", done, 0);

    // reset in CAPTURE: outputs clear at once, no done
    @(posedge clock); #1;
    start = 1'b1; start_addr = 4'd6; word_count = 5'd4; tx_ready = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check_eq("mid_rst_valid", tx_valid, 0);
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_done", done, 0);
    check_eq("mid_rst_addr", read_addr, 0);
    check_eq("mid_rst_data", tx_data, 0);
    d0 = done_count;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_eq("mid_rst_no_done", done_count - d0, 0);
    check_eq("mid_rst_idle", busy, 0);

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      run_dump(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
